// File: rtl/softsw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softsw_pkg
// Description : Shared definitions for the soft-switch command sequencer:
//               decoder opcodes, the NOP opcode, FSM states, and a helper
//               that recognises idle words.
// Revision    : 1.0 - initial release
// ============================================================================
package softsw_pkg;

   // Decoder opcodes (command bits [15:8])
   localparam logic [7:0] SOFTSW_OP_ROM_BANK   = 8'h00;
   localparam logic [7:0] SOFTSW_OP_RAM_BANK   = 8'h01;
   localparam logic [7:0] SOFTSW_OP_VIDEO_MODE = 8'h02;
   localparam logic [7:0] SOFTSW_OP_PALETTE    = 8'h03;
   localparam logic [7:0] SOFTSW_OP_SCANLINES  = 8'h04;
   localparam logic [7:0] SOFTSW_OP_VOLUME     = 8'h05;
   localparam logic [7:0] SOFTSW_OP_CPU_SPEED  = 8'h06;
   localparam logic [7:0] SOFTSW_OP_JOY_SWAP   = 8'h07;
   localparam logic [7:0] SOFTSW_OP_DISK_SEL   = 8'h08;
   localparam logic [7:0] SOFTSW_OP_TAPE_CTRL  = 8'h09;
   localparam logic [7:0] SOFTSW_OP_OSD_SHOW   = 8'h0A;
   localparam logic [7:0] SOFTSW_OP_KEY_MAP    = 8'h0B;
   localparam logic [7:0] SOFTSW_OP_PAUSE      = 8'h0C;
   localparam logic [7:0] SOFTSW_OP_RESET      = 8'h0D;

   // Opcode the decoder never acts on
   localparam logic [7:0] SOFTSW_OP_NOP        = 8'hFF;

   // Output sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } softsw_state_e;

   // True when a command carries the idle opcode
   function automatic logic is_nop(input logic [15:0] cmd, input logic [15:0] nop_word);
      return cmd[15:8] == nop_word[15:8];
   endfunction

endpackage : softsw_pkg
`default_nettype wire

// File: rtl/softsw_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : softsw_cmd_fifo
// Description : Synchronous command FIFO, power-of-two depth, wrapping
//               pointers and an occupancy counter. With
//               SOFTSW_SEQ_COALESCE_EN defined it also exposes the most
//               recently written entry and lets it be overwritten in place.
// Revision    : 1.0 - initial release
// ============================================================================
module softsw_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
`ifdef SOFTSW_SEQ_COALESCE_EN
   input  logic             ovr_i,
   output logic [WIDTH-1:0] tail_o,
`endif
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_tail_idx;

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign dout_o     = mem_q[rd_q];
   assign w_push     = push_i && !full_o;
   assign w_pop      = pop_i && !empty_o;
   assign w_tail_idx = wr_q - 1'b1;

`ifdef SOFTSW_SEQ_COALESCE_EN
   assign tail_o = mem_q[w_tail_idx];
`endif

   // Pointer and occupancy bookkeeping; push and pop together leave occupancy unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (w_push) wr_q <= wr_q + 1'b1;
         if (w_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop);
      end
   end

   // Entry storage; the tail overwrite is never requested together with a push
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_q] <= din_i;
`ifdef SOFTSW_SEQ_COALESCE_EN
      if (ovr_i)  mem_q[w_tail_idx] <= din_i;
`endif
   end

endmodule : softsw_cmd_fifo
`default_nettype wire

// File: rtl/softsw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : softsw_sequencer
// Description : Round-robin arbiter for two command sources, command queue,
//               and output FSM that holds each command on the soft-switch bus
//               followed by a NOP gap so the decoder fires once per command.
//               Optional macro SOFTSW_SEQ_COALESCE_EN: a command with the same
//               opcode as the still-queued tail entry replaces its data.
// Revision    : 1.0 - initial release
// ============================================================================
module softsw_sequencer
   import softsw_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter int          HOLD_CYCLES = 4,
   parameter logic [15:0] NOP_CMD     = 16'hFF00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [15:0] req0_cmd,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_cmd,
   output logic        req1_ready,
   output logic [15:0] softsw_command,
   output logic        busy
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   softsw_state_e state_q, state_d;
   logic [HW-1:0] cnt_q, cnt_d;
   logic [15:0]   bus_q, bus_d;
   logic          busy_q, busy_d;
   logic          rr_q, rr_d;

   logic          w_full, w_empty;
   logic [CW-1:0] w_count, w_occ_next;
   logic [15:0]   w_head, w_cmd;
   logic          w_gnt0, w_gnt1, w_acc, w_drop, w_coal, w_push, w_pop;

   // Grant: a lone requester wins; on contention the pointer source wins
   assign w_gnt0     = req0_valid && (!req1_valid || !rr_q);
   assign w_gnt1     = req1_valid && (!req0_valid ||  rr_q);
   assign req0_ready = w_gnt0 && !w_full;
   assign req1_ready = w_gnt1 && !w_full;

   assign w_acc  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_cmd  = req0_ready ? req0_cmd : req1_cmd;
   assign w_drop = is_nop(w_cmd, NOP_CMD);

`ifdef SOFTSW_SEQ_COALESCE_EN
   logic [15:0] w_tail;
   logic        w_tail_live;
   // The tail is no longer queued if it is the only entry and is leaving now
   assign w_tail_live = !w_empty && !(w_pop && (w_count == CW'(1)));
   assign w_coal      = w_acc && !w_drop && w_tail_live && (w_tail[15:8] == w_cmd[15:8]);
`else
   assign w_coal      = 1'b0;
`endif

   assign w_push     = w_acc && !w_drop && !w_coal;
   assign rr_d       = (req0_valid && req1_valid && w_acc) ? !rr_q : rr_q;
   assign w_occ_next = w_count + CW'(w_push) - CW'(w_pop);
   assign busy_d     = (state_d != IDLE) || (w_occ_next != '0);

   softsw_cmd_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .WIDTH   (16)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   (w_cmd),
`ifdef SOFTSW_SEQ_COALESCE_EN
      .ovr_i   (w_coal),
      .tail_o  (w_tail),
`endif
      .dout_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   // Output sequencing: load a command, hold it, then hold NOP before the next
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bus_d   = bus_q;
      w_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_empty) begin
               bus_d   = w_head;
               w_pop   = 1'b1;
               cnt_d   = HOLD_LAST;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               bus_d   = NOP_CMD;
               cnt_d   = HOLD_LAST;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!w_empty) begin
               bus_d   = w_head;
               w_pop   = 1'b1;
               cnt_d   = HOLD_LAST;
               state_d = HOLD;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            bus_d   = NOP_CMD;
            cnt_d   = '0;
         end
      endcase
   end

   // State, bus, busy and round-robin registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bus_q   <= NOP_CMD;
         busy_q  <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_d;
         busy_q  <= busy_d;
         rr_q    <= rr_d;
      end
   end

   assign softsw_command = bus_q;
   assign busy           = busy_q;

endmodule : softsw_sequencer
`default_nettype wire

// File: tb/tb_softsw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_softsw_sequencer
// Description : Self-checking bench for softsw_sequencer: vector table,
//               directed multi-cycle sequences and random traffic compared
//               against a queue/timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softsw_sequencer;

   localparam int          D   = 4;
   localparam int          H   = 4;
   localparam logic [15:0] NOP = 16'hFF00;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_cmd = '0, req1_cmd = '0;
   logic        req0_ready, req1_ready, busy;
   logic [15:0] softsw_command;

   always #5 clk = ~clk;

   softsw_sequencer #(
      .FIFO_DEPTH     (D),
      .HOLD_CYCLES    (H),
      .NOP_CMD        (NOP)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req0_valid     (req0_valid),
      .req0_cmd       (req0_cmd),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_cmd       (req1_cmd),
      .req1_ready     (req1_ready),
      .softsw_command (softsw_command),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: pending queue plus the age of the command slot on the bus
   logic [15:0] mq[$];
   bit          m_active;
   int          m_age;
   logic [15:0] m_cur;
   bit          m_rr;

   logic [15:0] bus_log[$];
   int          acc_src[$];
   logic [15:0] iss[$];
   logic        s_r0, s_r1;

   typedef struct {
      logic        v0;
      logic [15:0] c0;
      logic        v1;
      logic [15:0] c1;
      logic        r0;
      logic        r1;
      logic [15:0] bus;
      logic        bsy;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(logic v0, logic [15:0] c0, logic v1, logic [15:0] c1,
                               logic r0, logic r1, logic [15:0] bus, logic bsy);
      vec_t v;
      v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1;
      v.r0 = r0; v.r1 = r1; v.bus = bus; v.bsy = bsy;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkint(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_cur    = NOP;
      m_rr     = 1'b0;
      bus_log.delete();
      acc_src.delete();
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_cmd   = '0;   req1_cmd   = '0;
      reset_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk16("reset_bus", softsw_command, NOP);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_r0", req0_ready, 1'b0);
      chk1("reset_r1", req1_ready, 1'b0);
      reset_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, check readies, advance model, check bus and busy
   task automatic step(input logic v0, input logic [15:0] c0, input logic v1, input logic [15:0] c1);
      bit          full, g0, g1, e0, e1;
      logic [15:0] cmd;
      req0_valid = v0; req0_cmd = c0;
      req1_valid = v1; req1_cmd = c1;
      #1;
      full = (mq.size() == D);
      g0   = v0 && (!v1 || !m_rr);
      g1   = v1 && (!v0 ||  m_rr);
      e0   = g0 && !full;
      e1   = g1 && !full;
      s_r0 = req0_ready;
      s_r1 = req1_ready;
      chk1("req0_ready", req0_ready, e0);
      chk1("req1_ready", req1_ready, e1);
      @(posedge clk);
      if (m_active) begin
         m_age++;
         if (m_age == 2 * H) m_active = 1'b0;
      end
      if (!m_active && mq.size() != 0) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_age    = 0;
      end
      if (e0 || e1) begin
         cmd = e0 ? c0 : c1;
         if (v0 && v1) m_rr = !m_rr;
         if (cmd[15:8] != NOP[15:8]) begin
`ifdef SOFTSW_SEQ_COALESCE_EN
            if (mq.size() != 0 && mq[mq.size()-1][15:8] == cmd[15:8]) mq[mq.size()-1] = cmd;
            else mq.push_back(cmd);
`else
            mq.push_back(cmd);
`endif
         end
      end
      #1;
      if (s_r0 && v0) acc_src.push_back(0);
      else if (s_r1 && v1) acc_src.push_back(1);
      bus_log.push_back(softsw_command);
      chk16("bus", softsw_command, (m_active && m_age < H) ? m_cur : NOP);
      chk1("busy", busy, (m_active || mq.size() != 0) ? 1'b1 : 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   // Commands issued on the bus, in order, taken from the logged bus values
   task automatic build_issued();
      iss.delete();
      for (int i = 0; i < bus_log.size(); i++)
         if (bus_log[i] != NOP && (i == 0 || bus_log[i-1] != bus_log[i])) iss.push_back(bus_log[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          i0, k, stalls;
      logic [15:0] exp_q[$];
      logic        rv0, rv1;
      logic [7:0]  op0, op1;

      tbl[0]  = mk(1'b1, 16'h0601, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFF00, 1'b1);
      tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0601, 1'b1);
      tbl[2]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0601, 1'b1);
      tbl[3]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0601, 1'b1);
      tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0601, 1'b1);
      tbl[5]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b1);
      tbl[6]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b1);
      tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b1);
      tbl[8]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b1);
      tbl[9]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b0);
      tbl[10] = mk(1'b0, 16'h0000, 1'b1, 16'hFF12, 1'b0, 1'b1, 16'hFF00, 1'b0);
      tbl[11] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b0);
      tbl[12] = mk(1'b1, 16'h0201, 1'b1, 16'h0501, 1'b1, 1'b0, 16'hFF00, 1'b1);
      tbl[13] = mk(1'b1, 16'h0202, 1'b1, 16'h0501, 1'b0, 1'b1, 16'h0201, 1'b1);
      tbl[14] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0201, 1'b1);

      // Vector table: single command timing, NOP filter, first arbitration
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1);
         chk1($sformatf("tbl%0d_r0", i), s_r0, tbl[i].r0);
         chk1($sformatf("tbl%0d_r1", i), s_r1, tbl[i].r1);
         chk16($sformatf("tbl%0d_bus", i), softsw_command, tbl[i].bus);
         chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      end

      // Repeated command back-to-back: separated by a NOP gap
      do_reset();
      step(1'b1, 16'h0B01, 1'b0, 16'h0);
      step(1'b1, 16'h0B01, 1'b0, 16'h0);
      idle(20);
      i0 = -1;
      for (int i = 0; i < bus_log.size() && i0 < 0; i++)
         if (bus_log[i] == 16'h0B01) i0 = i;
      chkint("repeat_latency", i0, 1);
      if (i0 >= 0 && i0 + 16 <= bus_log.size()) begin
         for (int j = 0; j < 16; j++)
            chk16($sformatf("repeat_slot%0d", j), bus_log[i0+j], ((j / 4) % 2 == 0) ? 16'h0B01 : NOP);
      end

      // Contested sources alternate
      do_reset();
      for (int i = 0; i < 8; i++)
         step(1'b1, {8'h02, 8'(i)}, 1'b1, {8'h05, 8'(i)});
      chkint("rr_accepts", acc_src.size(), 5);
      for (int i = 0; i < 4 && i < acc_src.size(); i++)
         chkint($sformatf("rr_src%0d", i), acc_src[i], i % 2);
      idle(48);
      build_issued();
      exp_q = '{16'h0200, 16'h0501, 16'h0202, 16'h0503, 16'h0204};
      chkint("rr_issued_n", iss.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < iss.size(); i++)
         chk16($sformatf("rr_issued%0d", i), iss[i], exp_q[i]);

      // Queue fills while the bus is busy: stall, resume, no loss
      do_reset();
      step(1'b1, 16'h0601, 1'b0, 16'h0);
      k = 0;
      stalls = 0;
      for (int t = 0; t < 80 && k < 6; t++) begin
         step(1'b1, {8'h07, 8'(k)}, 1'b0, 16'h0);
         if (s_r0) k++;
         else stalls++;
      end
      chkint("fill_accepted", k, 6);
      chkint("fill_stalls", stalls, 12);
      idle(60);
      build_issued();
      exp_q = '{16'h0601, 16'h0700, 16'h0701, 16'h0702, 16'h0703, 16'h0704, 16'h0705};
      chkint("fill_issued_n", iss.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < iss.size(); i++)
         chk16($sformatf("fill_issued%0d", i), iss[i], exp_q[i]);

      // Same opcode queued twice behind a busy bus
      do_reset();
      step(1'b1, 16'h0601, 1'b0, 16'h0);
      step(1'b1, 16'h0300, 1'b0, 16'h0);
      step(1'b1, 16'h0302, 1'b0, 16'h0);
      idle(40);
      build_issued();
`ifdef SOFTSW_SEQ_COALESCE_EN
      exp_q = '{16'h0601, 16'h0302};
`else
      exp_q = '{16'h0601, 16'h0300, 16'h0302};
`endif
      chkint("coal_issued_n", iss.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < iss.size(); i++)
         chk16($sformatf("coal_issued%0d", i), iss[i], exp_q[i]);

      // Reset during HOLD clears the bus at once and discards the queue
      do_reset();
      step(1'b1, 16'h0601, 1'b0, 16'h0);
      step(1'b1, 16'h0602, 1'b0, 16'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0);
      chk16("pre_rst_bus", softsw_command, 16'h0601);
      #2;
      reset_n = 1'b0;
      #1;
      chk16("async_rst_bus", softsw_command, NOP);
      chk1("async_rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      idle(12);
      build_issued();
      chkint("post_rst_issued_n", iss.size(), 0);

      // Random traffic against the reference model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rv0 = ($urandom_range(0, 99) < 35);
         rv1 = ($urandom_range(0, 99) < 35);
         op0 = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
         op1 = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
         step(rv0, {op0, 8'($urandom_range(0, 255))}, rv1, {op1, 8'($urandom_range(0, 255))});
      end
      idle(48);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_softsw_sequencer
`default_nettype wire
